// File: rtl/uart_rx_buffer_pkg.sv
// Shared constants for the UART receive buffer slice: byte width and the
// one-hot capture FSM encoding.
package uart_pkg;
    localparam int unsigned UART_BYTE_W = 8;

    typedef enum logic [3:0] {
        RXB_IDLE    = 4'b0001,
        RXB_STROBE  = 4'b0010,
        RXB_CAPTURE = 4'b0100,
        RXB_HOLD    = 4'b1000
    } rxb_state_t;
endpackage

// File: rtl/uart_rx_buffer_if.sv
// Host-side pop/status interface of the UART receive buffer.
interface uart_rx_buffer_if #(
    parameter int unsigned ADDR_W = 4
);
    import uart_pkg::*;

    logic                   rd_en;
    logic                   ovf_clr;
    logic [UART_BYTE_W-1:0] rd_data;
    logic                   rd_valid;
    logic                   empty;
    logic                   full;
    logic [ADDR_W:0]        count;
    logic                   overflow;

    modport master (
        output rd_en, ovf_clr,
        input  rd_data, rd_valid, empty, full, count, overflow
    );

    modport slave (
        input  rd_en, ovf_clr,
        output rd_data, rd_valid, empty, full, count, overflow
    );
endinterface

// File: rtl/uart_rx_buffer_fifo.sv
// Synchronous byte FIFO with registered pop data, occupancy flags and a
// sticky overflow bit for pushes that find no free slot.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                   clk_sample,
    input  logic                   rst,
    input  logic                   push,
    input  logic [UART_BYTE_W-1:0] wr_data,
    uart_rx_buffer_if.slave        host
);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);

    logic [UART_BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr;
    logic [ADDR_W-1:0]      rd_ptr;
    logic                   do_pop;
    logic                   do_push;
    logic [ADDR_W:0]        count_nxt;

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    always_comb begin
        do_pop    = host.rd_en & ~host.empty;
        do_push   = push & (~host.full | do_pop);
        count_nxt = host.count;
        if (do_push & ~do_pop)
            count_nxt = host.count + ONE_CNT;
        else if (do_pop & ~do_push)
            count_nxt = host.count - ONE_CNT;
    end

    always_ff @(posedge clk_sample) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk_sample or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            host.count    <= '0;
            host.empty    <= 1'b1;
            host.full     <= 1'b0;
            host.rd_data  <= '0;
            host.rd_valid <= 1'b0;
            host.overflow <= 1'b0;
        end else begin
            host.rd_valid <= do_pop;
            if (do_pop) begin
                host.rd_data <= mem[rd_ptr];
                rd_ptr       <= rd_ptr + 1'b1;
            end
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            host.count <= count_nxt;
            host.empty <= (count_nxt == '0);
            host.full  <= (count_nxt == DEPTH_CNT);
            if (push & ~do_push)
                host.overflow <= 1'b1;
            else if (host.ovf_clr)
                host.overflow <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_rx_buffer.sv
// Reads bytes from the UART receiver via its data_ready / active-low read
// strobe handshake and buffers them for the host in a local FIFO.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                   clk_sample,
    input  logic                   rst,
    input  logic                   rx_ready,
    input  logic [UART_BYTE_W-1:0] rx_data,
    output logic                   rx_rdn,
    uart_rx_buffer_if.slave        host
);
    rxb_state_t             state;
    logic                   rdy_d;
    logic                   rdy_rise;
    logic                   push;
    logic [UART_BYTE_W-1:0] cap_byte;

    assign rdy_rise = rx_ready & ~rdy_d;

    // rx_rdn is registered alongside the state so it is low exactly while
    // the FSM sits in STROBE and CAPTURE; push is issued from HOLD.
    always_ff @(posedge clk_sample or negedge rst) begin
        if (!rst) begin
            state    <= RXB_IDLE;
            rdy_d    <= 1'b0;
            rx_rdn   <= 1'b1;
            push     <= 1'b0;
            cap_byte <= '0;
        end else begin
            rdy_d <= rx_ready;
            push  <= 1'b0;
            unique case (state)
                RXB_IDLE: begin
                    rx_rdn <= 1'b1;
                    if (rdy_rise) begin
                        state  <= RXB_STROBE;
                        rx_rdn <= 1'b0;
                    end
                end
                RXB_STROBE: begin
                    state  <= RXB_CAPTURE;
                    rx_rdn <= 1'b0;
                end
                RXB_CAPTURE: begin
                    cap_byte <= rx_data;
                    push     <= 1'b1;
                    rx_rdn   <= 1'b1;
                    state    <= RXB_HOLD;
                end
                RXB_HOLD: begin
                    rx_rdn <= 1'b1;
                    if (!rx_ready)
                        state <= RXB_IDLE;
                end
                default: begin
                    state  <= RXB_IDLE;
                    rx_rdn <= 1'b1;
                end
            endcase
        end
    end

    uart_byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_sample (clk_sample),
        .rst        (rst),
        .push       (push),
        .wr_data    (cap_byte),
        .host       (host)
    );
endmodule
